// File: rtl/pe_dbuf_mac.sv
// pe_dbuf_mac: weight-stationary systolic processing element with a
// double-buffered weight. A shadow weight is captured from the psum column
// during the load phase while the active weight keeps computing; weight_swap
// promotes shadow to active.
//
// Optional feature macro: PE_SAT_EN (saturating accumulate + sticky sat_flag).
// Without it the accumulate wraps modulo 2^ACC_WIDTH and sat_flag stays 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   signed_mode         1 = two's complement operands, 0 = unsigned
//   en_weight_pass      load phase: pass psum column through, no compute
//   en_weight_capture   capture psum_in[WEIGHT_WIDTH-1:0] into shadow (load phase only)
//   weight_swap         active weight <= shadow weight
//   act_valid_in/act_in activation (and its valid tag) from the left
//   psum_in             partial sum from above (also carries weight in load phase)
//   act_valid_out/act_out  registered activation to the right
//   psum_out            registered partial sum downward
//   weight_ready        active weight loaded at least once since reset
//   sat_flag/clear_sat  sticky saturation indicator and its synchronous clear
module pe_dbuf_mac #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    signed_mode,
    input  logic                    en_weight_pass,
    input  logic                    en_weight_capture,
    input  logic                    weight_swap,
    input  logic                    act_valid_in,
    input  logic [DATA_WIDTH-1:0]   act_in,
    input  logic [ACC_WIDTH-1:0]    psum_in,
    output logic                    act_valid_out,
    output logic [DATA_WIDTH-1:0]   act_out,
    output logic [ACC_WIDTH-1:0]    psum_out,
    output logic                    weight_ready,
    output logic                    sat_flag,
    input  logic                    clear_sat
);

    // One extra bit on each operand lets a single signed multiplier serve
    // both modes: the extra bit is the sign in signed mode and 0 otherwise.
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH + 2;

    logic [WEIGHT_WIDTH-1:0]        shadow_w;
    logic [WEIGHT_WIDTH-1:0]        active_w;

    logic signed [DATA_WIDTH:0]     a_ext;
    logic signed [WEIGHT_WIDTH:0]   w_ext;
    logic signed [PW-1:0]           prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH:0]             sum;
    logic [ACC_WIDTH-1:0]           mac_res;
    logic                           sat_evt;
    logic                           do_mac;

    assign a_ext = {signed_mode & act_in[DATA_WIDTH-1], act_in};
    assign w_ext = {signed_mode & active_w[WEIGHT_WIDTH-1], active_w};
    assign prod  = PW'(a_ext) * PW'(w_ext);
    // Product always fits in ACC_WIDTH; in unsigned mode it is non-negative,
    // so sign extension here equals zero extension.
    assign prod_ext = ACC_WIDTH'(prod);
    assign sum      = {1'b0, psum_in} + {1'b0, prod_ext};

    // A MAC happens only in compute phase, with a loaded weight and a real sample.
    assign do_mac = !en_weight_pass && weight_ready && act_valid_in;

`ifdef PE_SAT_EN
    logic ovf_s;
    logic ovf_u;

    always_comb begin
        ovf_s   = signed_mode && (psum_in[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1])
                              && (sum[ACC_WIDTH-1] != psum_in[ACC_WIDTH-1]);
        ovf_u   = !signed_mode && sum[ACC_WIDTH];
        sat_evt = do_mac && (ovf_s || ovf_u);
        mac_res = sum[ACC_WIDTH-1:0];
        if (ovf_u)
            mac_res = '1;
        else if (ovf_s)
            // Operand signs agree on overflow, so psum_in's sign picks the rail.
            mac_res = psum_in[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    always_comb begin
        sat_evt = 1'b0;
        mac_res = sum[ACC_WIDTH-1:0];
    end

    wire unused_sat = &{1'b0, clear_sat, sum[ACC_WIDTH], sat_evt};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_out       <= '0;
            act_valid_out <= 1'b0;
            psum_out      <= '0;
            weight_ready  <= 1'b0;
            sat_flag      <= 1'b0;
            shadow_w      <= '0;
            active_w      <= '0;
        end else begin
            // Swap reads the pre-edge shadow, so a same-cycle capture lands
            // in the shadow for the next swap.
            if (weight_swap) begin
                active_w     <= shadow_w;
                weight_ready <= 1'b1;
            end

            if (en_weight_pass) begin
                psum_out      <= psum_in;
                act_out       <= '0;
                act_valid_out <= 1'b0;
                if (en_weight_capture)
                    shadow_w <= psum_in[WEIGHT_WIDTH-1:0];
            end else begin
                act_out       <= act_valid_in ? act_in : '0;
                act_valid_out <= act_valid_in;
                psum_out      <= do_mac ? mac_res : psum_in;
            end

`ifdef PE_SAT_EN
            // Set wins over a same-cycle clear.
            if (sat_evt)
                sat_flag <= 1'b1;
            else if (clear_sat)
                sat_flag <= 1'b0;
`else
            sat_flag <= 1'b0;
`endif
        end
    end

endmodule
